// File: rtl/store_pkg.sv
// Shared definitions for the store data path: funct3 codes, FSM states,
// byte masks and the lane shifter result bundle.
package store_pkg;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ_LO,
        ST_REQ_HI,
        ST_DONE,
        ST_ERR
    } state_t;

    // be8/d64 span two words: [3:0]/[31:0] is the low beat, [7:4]/[63:32] the high beat
    typedef struct packed {
        logic [7:0]  be8;
        logic [63:0] d64;
        logic        misaligned;
        logic        invalid;
    } lane_t;

endpackage

// File: rtl/store_lane_shifter.sv
// Purpose: position store bytes into two-word lanes and flag bad/misaligned stores.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module store_lane_shifter
    import store_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    input  logic [31:0] data,
    output lane_t       lane
);

    logic [3:0]  mask;
    logic [31:0] data_m;

    always_comb begin
        mask            = '0;
        data_m          = '0;
        lane.invalid    = 1'b0;
        lane.misaligned = 1'b0;
        case (funct3)
            F3_SB: begin
                mask   = MASK_B;
                data_m = {24'b0, data[7:0]};
            end
            F3_SH: begin
                mask            = MASK_H;
                data_m          = {16'b0, data[15:0]};
                lane.misaligned = (off == 2'b11);
            end
            F3_SW: begin
                mask            = MASK_W;
                data_m          = data;
                lane.misaligned = (off != 2'b00);
            end
            default: lane.invalid = 1'b1;
        endcase
        // Unused bytes are masked before shifting so disabled lanes stay zero
        lane.be8 = {4'b0, mask} << off;
        lane.d64 = {32'b0, data_m} << {off, 3'b000};
    end

endmodule

// File: rtl/store_data_aligner.sv
// Purpose: turn an RV32I store into one or two word-aligned memory writes with byte enables.
// Latency: accept T, mem_req T+1, st_done one cycle after the final grant (T+2 aligned, T+3 split).
// Backpressure: st_ready only in IDLE; beat outputs held stable while mem_gnt is low.
module store_data_aligner
    import store_pkg::*;
#(
    parameter bit ALLOW_MISALIGNED = 1'b1,
    parameter int ADDR_W           = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [31:0]       st_data,
    input  logic [2:0]        st_funct3,
    output logic              st_done,
    output logic              st_err,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_gnt
);

    state_t            state;
    state_t            state_nxt;
    lane_t             lane;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] hi_addr;
    logic [3:0]        hi_be;
    logic [31:0]       hi_wdata;

    store_lane_shifter u_shift (
        .off    (st_addr[1:0]),
        .funct3 (st_funct3),
        .data   (st_data),
        .lane   (lane)
    );

    assign base_addr = {st_addr[ADDR_W-1:2], 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        st_ready  = 1'b0;
        st_done   = 1'b0;
        st_err    = 1'b0;
        mem_req   = 1'b0;
        case (state)
            ST_IDLE: begin
                st_ready = 1'b1;
                if (st_valid) begin
                    if (lane.invalid || (lane.misaligned && !ALLOW_MISALIGNED)) begin
                        state_nxt = ST_ERR;
                    end else begin
                        state_nxt = ST_REQ_LO;
                    end
                end
            end
            ST_REQ_LO: begin
                mem_req = 1'b1;
                if (mem_gnt) begin
                    state_nxt = (hi_be != 4'b0) ? ST_REQ_HI : ST_DONE;
                end
            end
            ST_REQ_HI: begin
                mem_req = 1'b1;
                if (mem_gnt) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                st_done   = 1'b1;
                state_nxt = ST_IDLE;
            end
            ST_ERR: begin
                st_err    = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Beat registers: low beat loaded on accept, high beat swapped in on the low grant
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            hi_addr   <= '0;
            hi_be     <= '0;
            hi_wdata  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (state_nxt == ST_REQ_LO) begin
                        mem_addr  <= base_addr;
                        mem_be    <= lane.be8[3:0];
                        mem_wdata <= lane.d64[31:0];
                        hi_addr   <= base_addr + ADDR_W'(4);
                        hi_be     <= lane.be8[7:4];
                        hi_wdata  <= lane.d64[63:32];
                    end
                end
                ST_REQ_LO: begin
                    if (mem_gnt) begin
                        if (state_nxt == ST_REQ_HI) begin
                            mem_addr  <= hi_addr;
                            mem_be    <= hi_be;
                            mem_wdata <= hi_wdata;
                        end else begin
                            mem_addr  <= '0;
                            mem_be    <= '0;
                            mem_wdata <= '0;
                        end
                    end
                end
                ST_REQ_HI: begin
                    if (mem_gnt) begin
                        mem_addr  <= '0;
                        mem_be    <= '0;
                        mem_wdata <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_store_data_aligner.sv
// Randomized scoreboard bench for store_data_aligner, plus a second instance
// built with misaligned stores disallowed.
module tb_store_data_aligner;

    typedef struct {
        int          kind;   // 0 beat, 1 done, 2 err
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        st_valid = 1'b0;
    logic        st_ready;
    logic [31:0] st_addr = '0;
    logic [31:0] st_data = '0;
    logic [2:0]  st_funct3 = '0;
    logic        st_done, st_err, mem_req;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt = 1'b0;

    logic        na_valid = 1'b0;
    logic        na_ready;
    logic [31:0] na_addr = '0;
    logic [31:0] na_data = '0;
    logic [2:0]  na_f3 = '0;
    logic        na_done, na_err, na_req;
    logic [31:0] na_maddr, na_wdata;
    logic [3:0]  na_be;
    logic        na_gnt = 1'b1;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t exp_q[$];
    exp_t model_q[$];

    always #5 clk = ~clk;

    store_data_aligner #(.ALLOW_MISALIGNED(1'b1), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .st_valid(st_valid), .st_ready(st_ready),
        .st_addr(st_addr), .st_data(st_data), .st_funct3(st_funct3),
        .st_done(st_done), .st_err(st_err), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_gnt(mem_gnt)
    );

    store_data_aligner #(.ALLOW_MISALIGNED(1'b0), .ADDR_W(32)) dut_na (
        .clk(clk), .rst(rst), .st_valid(na_valid), .st_ready(na_ready),
        .st_addr(na_addr), .st_data(na_data), .st_funct3(na_f3),
        .st_done(na_done), .st_err(na_err), .mem_req(na_req),
        .mem_addr(na_maddr), .mem_wdata(na_wdata), .mem_be(na_be),
        .mem_gnt(na_gnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: walk the stored bytes one by one and group them by the word they land in
    task automatic model(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
        int   n;
        exp_t e;
        logic [31:0] ba, w;
        logic [1:0]  ln;
        model_q.delete();
        n = (f3 == 3'b000) ? 1 : (f3 == 3'b001) ? 2 : 4;
        for (int i = 0; i < n; i++) begin
            ba = a + 32'(i);
            w  = ba & ~32'h3;
            ln = ba[1:0];
            if (model_q.size() == 0 || model_q[model_q.size()-1].addr != w) begin
                e.kind = 0; e.addr = w; e.be = '0; e.wdata = '0;
                model_q.push_back(e);
            end
            e = model_q[model_q.size()-1];
            e.be[ln] = 1'b1;
            e.wdata[8*ln +: 8] = d[8*i +: 8];
            model_q[model_q.size()-1] = e;
        end
    endtask

    // Monitor: every presented beat must match the head; pop on grant / completion pulses
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_req) begin
                vectors++;
                if (exp_q.size() == 0 || exp_q[0].kind != 0) begin
                    miscompares++;
                    $display("FAIL unexpected_req: got addr 0x%0h be %b, expected no request", mem_addr, mem_be);
                end else begin
                    chk("beat_addr", 64'(mem_addr), 64'(exp_q[0].addr));
                    chk("beat_be", 64'(mem_be), 64'(exp_q[0].be));
                    chk("beat_wdata", 64'(mem_wdata), 64'(exp_q[0].wdata));
                    if (mem_gnt) void'(exp_q.pop_front());
                end
            end
            if (st_done) begin
                vectors++;
                if (exp_q.size() == 0 || exp_q[0].kind != 1) begin
                    miscompares++;
                    $display("FAIL unexpected_done: got st_done=1, expected pending item kind %0d", (exp_q.size() == 0) ? -1 : exp_q[0].kind);
                end else void'(exp_q.pop_front());
            end
            if (st_err) begin
                vectors++;
                if (exp_q.size() == 0 || exp_q[0].kind != 2) begin
                    miscompares++;
                    $display("FAIL unexpected_err: got st_err=1, expected pending item kind %0d", (exp_q.size() == 0) ? -1 : exp_q[0].kind);
                end else void'(exp_q.pop_front());
            end
            if (st_done && st_err) chk("done_err_excl", 64'(st_done & st_err), 64'd0);
        end
    end

    // Issues one store; called and returns at posedge+1. rst_hi: reset while the high beat waits.
    task automatic run_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3,
                             input int wlo, input int whi, input bit rst_hi);
        int   t = 0;
        int   nb;
        exp_t e;
        while (st_ready !== 1'b1 && t < 20) begin
            @(posedge clk); #1; t++;
        end
        chk("ready_wait", 64'(st_ready), 64'd1);
        if (f3 > 3'b010) begin
            e.kind = 2; e.addr = '0; e.be = '0; e.wdata = '0;
            exp_q.push_back(e);
            nb = 0;
        end else begin
            model(a, d, f3);
            nb = model_q.size();
            foreach (model_q[i]) exp_q.push_back(model_q[i]);
            e.kind = 1; e.addr = '0; e.be = '0; e.wdata = '0;
            exp_q.push_back(e);
        end
        st_valid = 1'b1; st_addr = a; st_data = d; st_funct3 = f3;
        @(posedge clk); #1;
        st_valid = 1'b0; st_addr = $urandom; st_data = $urandom; st_funct3 = 3'($urandom);
        if (nb == 0) begin
            @(negedge clk);
            chk("err_pulse", 64'(st_err), 64'd1);
            chk("err_no_req", 64'(mem_req), 64'd0);
            chk("err_not_ready", 64'(st_ready), 64'd0);
            @(posedge clk); #1;
            chk("err_ready_back", 64'(st_ready), 64'd1);
            chk("err_single", 64'(st_err), 64'd0);
            return;
        end
        for (int b = 0; b < nb; b++) begin
            mem_gnt = 1'b0;
            repeat ((b == 0) ? wlo : whi) begin
                @(negedge clk);
                chk("req_held", 64'(mem_req), 64'd1);
                @(posedge clk); #1;
            end
            if (rst_hi && b == 1) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                exp_q.delete();
                @(negedge clk);
                chk("rst_req", 64'(mem_req), 64'd0);
                chk("rst_ready", 64'(st_ready), 64'd1);
                chk("rst_no_done", 64'(st_done), 64'd0);
                chk("rst_be", 64'(mem_be), 64'd0);
                @(posedge clk); #1;
                return;
            end
            mem_gnt = 1'b1;
            @(negedge clk);
            chk("req_present", 64'(mem_req), 64'd1);
            @(posedge clk); #1;
            mem_gnt = 1'b0;
        end
        @(negedge clk);
        chk("done_pulse", 64'(st_done), 64'd1);
        chk("done_req_low", 64'(mem_req), 64'd0);
        chk("done_not_ready", 64'(st_ready), 64'd0);
        @(posedge clk); #1;
        chk("done_single", 64'(st_done), 64'd0);
        chk("ready_after_done", 64'(st_ready), 64'd1);
    endtask

    initial begin
        logic [31:0] a;
        logic [2:0]  f3;
        int          sel;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_st_ready", 64'(st_ready), 64'd1);
        chk("rst_st_done", 64'(st_done), 64'd0);
        chk("rst_st_err", 64'(st_err), 64'd0);
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_mem_be", 64'(mem_be), 64'd0);
        @(posedge clk); #1;

        // Misalignment disallowed: SW at 0x2 errors, SH at 0x1 still goes through
        na_valid = 1'b1; na_addr = 32'h2; na_data = 32'h11223344; na_f3 = 3'b010;
        @(posedge clk); #1;
        na_valid = 1'b0;
        @(negedge clk);
        chk("na_err_pulse", 64'(na_err), 64'd1);
        chk("na_err_no_req", 64'(na_req), 64'd0);
        @(posedge clk); #1;
        chk("na_ready_back", 64'(na_ready), 64'd1);
        chk("na_err_single", 64'(na_err), 64'd0);
        na_valid = 1'b1; na_addr = 32'h1; na_data = 32'h0000BEEF; na_f3 = 3'b001;
        @(posedge clk); #1;
        na_valid = 1'b0;
        @(negedge clk);
        chk("na_sh_req", 64'(na_req), 64'd1);
        chk("na_sh_addr", 64'(na_maddr), 64'h0);
        chk("na_sh_be", 64'(na_be), 64'b0110);
        chk("na_sh_wdata", 64'(na_wdata), 64'h00BEEF00);
        @(posedge clk); #1;
        @(negedge clk);
        chk("na_sh_done", 64'(na_done), 64'd1);
        chk("na_sh_req_low", 64'(na_req), 64'd0);
        @(posedge clk); #1;

        run_store(32'h100, 32'hDEADBEEF, 3'b010, 0, 0, 1'b0);
        run_store(32'h203, 32'h12345678, 3'b000, 0, 0, 1'b0);
        run_store(32'h303, 32'h0000ABCD, 3'b001, 0, 0, 1'b0);
        run_store(32'h402, 32'h11223344, 3'b010, 3, 3, 1'b0);
        run_store(32'hFFFFFFFF, 32'hA1B2C3D4, 3'b010, 1, 2, 1'b0);
        run_store(32'h500, 32'h0, 3'b011, 0, 0, 1'b0);
        run_store(32'h601, 32'h55667788, 3'b010, 0, 2, 1'b1);
        run_store(32'h10, 32'hCAFEF00D, 3'b010, 0, 0, 1'b0);

        for (int k = 0; k < 120; k++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0)      f3 = 3'($urandom_range(3, 7));
            else               f3 = 3'($urandom_range(0, 2));
            a = $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'hFFFFFFFC | 32'($urandom_range(0, 3));
            run_store(a, $urandom, f3, $urandom_range(0, 2), $urandom_range(0, 2), 1'b0);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "timeout");
    end

endmodule
